// File: rtl/vga_timing_ctrl_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, the RGB 4:4:4 pixel
// type and the colour-bar lookup used by the optional test pattern
// (VGA_TEST_PATTERN_EN).
package vga_pack;

    // Default 640x480@60 timing, counted in pixels and lines
    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT
                                          + VGA_H_SYNC + VGA_H_BACK;

    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;
    localparam int unsigned VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT
                                          + VGA_V_SYNC + VGA_V_BACK;

    // Counters are fixed at 10 bits
    localparam int unsigned VGA_CNT_W = 10;

    // One pixel as it travels to the DAC
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Eight vertical bars, bar 0 in the least significant slot:
    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [8*12-1:0] VGA_BAR_LUT = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F,
        12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

    // Colour of bar number idx
    function automatic rgb444_t bar_colour(input logic [2:0] idx);
        return rgb444_t'(VGA_BAR_LUT[32'(idx) * 12 +: 12]);
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate enable generator: a 0..CLK_DIV-1 divider that raises
// pixel_tick for one system clock while the divider sits at CLK_DIV-1.
// The tick is registered so it is low during reset even when CLK_DIV=1.
module vga_pixel_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pixel_tick
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div_q;
    logic [3:0] div_d;
    logic       tick_q;
    logic       tick_d;

    // Next divider value and whether that value is the tick slot
    always_comb begin
        div_d = div_q + 4'd1;
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
        tick_d = (div_d == DIV_LAST);
    end

    // Divider and tick registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign pixel_tick = tick_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller and DAC output stage. Generates the pixel position
// from a divided pixel tick, tells the upstream source which pixel to
// supply, and registers sync and colour one pixel period later so they
// stay mutually aligned at the DAC.
// Optional feature: define VGA_TEST_PATTERN_EN to add the test_mode input
// that replaces data_in with eight vertical colour bars.
module vga_timing_ctrl
    import vga_pack::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] data_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic        pixel_tick,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [VGA_CNT_W-1:0] H_LAST   = VGA_CNT_W'(H_TOTAL - 1);
    localparam logic [VGA_CNT_W-1:0] V_LAST   = VGA_CNT_W'(V_TOTAL - 1);
    localparam logic [VGA_CNT_W-1:0] H_VIS    = VGA_CNT_W'(H_VISIBLE);
    localparam logic [VGA_CNT_W-1:0] V_VIS    = VGA_CNT_W'(V_VISIBLE);
    localparam logic [VGA_CNT_W-1:0] HS_START = VGA_CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [VGA_CNT_W-1:0] HS_END   = VGA_CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [VGA_CNT_W-1:0] VS_START = VGA_CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [VGA_CNT_W-1:0] VS_END   = VGA_CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic                 tick;
    logic [VGA_CNT_W-1:0] h_q;
    logic [VGA_CNT_W-1:0] h_d;
    logic [VGA_CNT_W-1:0] v_q;
    logic [VGA_CNT_W-1:0] v_d;
    logic                 vis;
    logic                 hs_active;
    logic                 vs_active;
    rgb444_t              src_colour;
    rgb444_t              rgb_q;
    rgb444_t              rgb_d;
    logic                 hsync_q;
    logic                 hsync_d;
    logic                 vsync_q;
    logic                 vsync_d;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk        (clk),
        .rst        (rst),
        .pixel_tick (tick)
    );

    // Raster position: advance one pixel per tick, line and frame wrap together
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Raster position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Position decode for the current pixel, straight from the counters
    always_comb begin
        vis       = (h_q < H_VIS) && (v_q < V_VIS);
        hs_active = (h_q >= HS_START) && (h_q <= HS_END);
        vs_active = (v_q >= VS_START) && (v_q <= VS_END);
    end

    // Colour source: upstream pixel, or the bar pattern when selected
    always_comb begin
        src_colour = rgb444_t'(data_in);
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
            src_colour = bar_colour(h_q[9:7]);
        end
`endif
    end

    // Values the output stage captures on the next tick
    always_comb begin
        rgb_d   = vis ? src_colour : '0;
        hsync_d = hs_active ? SYNC_POL : ~SYNC_POL;
        vsync_d = vs_active ? SYNC_POL : ~SYNC_POL;
    end

    // Output stage: syncs and colour captured together once per pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q   <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
        end else if (tick) begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign pixel_tick  = tick;
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign video_on    = vis;
    assign frame_start = tick && (h_q == '0) && (v_q == '0);
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = rgb_q.r;
    assign green       = rgb_q.g;
    assign blue        = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl. Instance A uses the default 640x480 timing
// with CLK_DIV=4; instance B uses a tiny 16x9 raster with CLK_DIV=1 so
// whole frames and mid-frame resets fit in a short run.
// Define VGA_TEST_PATTERN_EN to exercise the colour-bar source.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Instance A: default timing, CLK_DIV=4
    logic        rst_a = 1'b1;
    logic [11:0] data_a = 12'h000;
    logic        tm_a = 1'b0;
    logic        a_tick, a_von, a_fs, a_hs, a_vs;
    logic [9:0]  a_x, a_y;
    logic [3:0]  a_r, a_g, a_b;

    vga_timing_ctrl #(
        .CLK_DIV (4)
    ) dut_a (
        .clk         (clk),
        .rst         (rst_a),
        .data_in     (data_a),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode   (tm_a),
`endif
        .pixel_tick  (a_tick),
        .pixel_x     (a_x),
        .pixel_y     (a_y),
        .video_on    (a_von),
        .frame_start (a_fs),
        .hsync       (a_hs),
        .vsync       (a_vs),
        .red         (a_r),
        .green       (a_g),
        .blue        (a_b)
    );

    // Instance B: 16x9 raster (h 8/2/3/3, v 4/1/2/2), CLK_DIV=1
    // hsync active for h 10..12, vsync active for v 5..6
    logic        rst_b = 1'b1;
    logic [11:0] data_b = 12'h5A5;
    logic        b_tick, b_von, b_fs, b_hs, b_vs;
    logic [9:0]  b_x, b_y;
    logic [3:0]  b_r, b_g, b_b;

    vga_timing_ctrl #(
        .CLK_DIV   (1),
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (3),
        .V_VISIBLE (4),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (2),
        .SYNC_POL  (1'b0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .data_in     (data_b),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode   (1'b0),
`endif
        .pixel_tick  (b_tick),
        .pixel_x     (b_x),
        .pixel_y     (b_y),
        .video_on    (b_von),
        .frame_start (b_fs),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .red         (b_r),
        .green       (b_g),
        .blue        (b_b)
    );

    // Advance one system clock and settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int unsigned ticks;
        int unsigned tick_pos;
        rst_a  = 1'b1;
        data_a = 12'hABC;
        step();
        step();
        tests++;
        if ({a_tick, a_fs, a_x, a_y, a_von, a_hs, a_vs, a_r, a_g, a_b} !==
            {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 12'h000}) begin
            fails++;
            $display("FAIL reset_state: tick=%b fs=%b x=%0d y=%0d von=%b hs=%b vs=%b rgb=%h, want 0 0 0 0 1 1 1 000",
                     a_tick, a_fs, a_x, a_y, a_von, a_hs, a_vs, {a_r, a_g, a_b});
        end
        rst_a    = 1'b0;
        ticks    = 0;
        tick_pos = 0;
        for (int unsigned i = 1; i <= 4; i++) begin
            step();
            if (a_tick) begin
                ticks++;
                tick_pos = i;
                tests++;
                if (a_fs !== 1'b1 || a_x !== 10'd0) begin
                    fails++;
                    $display("FAIL first_tick_frame_start: fs=%b x=%0d, want 1 0", a_fs, a_x);
                end
            end
        end
        tests++;
        if (ticks !== 1 || tick_pos !== 3) begin
            fails++;
            $display("FAIL first_tick_timing: %0d ticks, last after edge %0d, want 1 after edge 3", ticks, tick_pos);
        end
        tests++;
        if (a_x !== 10'd1 || a_tick !== 1'b0 || {a_r, a_g, a_b} !== 12'hABC) begin
            fails++;
            $display("FAIL first_pixel_out: x=%0d tick=%b rgb=%h, want 1 0 abc", a_x, a_tick, {a_r, a_g, a_b});
        end
    endtask

    // Rest of line 0: hsync window, blanking and between-tick data gating
    task automatic test_line();
        int unsigned hs_low, hs_bad, rgb_bad, first_bad;
        logic        tick_now;
        logic [9:0]  x_now;
        logic        wrapped;
        logic        exp_hs;
        logic [11:0] exp_rgb;
        hs_low = 0; hs_bad = 0; rgb_bad = 0; first_bad = 0; wrapped = 1'b0;
        for (int unsigned c = 0; c < 3300 && !wrapped; c++) begin
            data_a   = a_tick ? 12'hABC : 12'h123;
            tick_now = a_tick;
            x_now    = a_x;
            step();
            if (tick_now) begin
                exp_hs  = (x_now >= 10'd656 && x_now <= 10'd751) ? 1'b0 : 1'b1;
                exp_rgb = (x_now < 10'd640) ? 12'hABC : 12'h000;
                if (a_hs == 1'b0) hs_low++;
                if (a_hs !== exp_hs) begin
                    if (hs_bad == 0) first_bad = x_now;
                    hs_bad++;
                end
                if ({a_r, a_g, a_b} !== exp_rgb) begin
                    if (rgb_bad == 0) first_bad = x_now;
                    rgb_bad++;
                end
                if (x_now == 10'd799) begin
                    wrapped = 1'b1;
                    tests++;
                    if (a_x !== 10'd0 || a_y !== 10'd1) begin
                        fails++;
                        $display("FAIL line_wrap: x=%0d y=%0d, want 0 1", a_x, a_y);
                    end
                end
            end
        end
        tests++;
        if (!wrapped) begin
            fails++;
            $display("FAIL line_wrap_timeout: x=%0d y=%0d, want wrap within 3300 clks", a_x, a_y);
        end
        tests++;
        if (hs_low !== 96 || hs_bad !== 0) begin
            fails++;
            $display("FAIL hsync_window: %0d low ticks, %0d misplaced (first x=%0d), want 96 low 0 misplaced",
                     hs_low, hs_bad, first_bad);
        end
        tests++;
        if (rgb_bad !== 0) begin
            fails++;
            $display("FAIL rgb_gating: %0d wrong pixels (first x=%0d), want 0", rgb_bad, first_bad);
        end
        tests++;
        if (a_vs !== 1'b1) begin
            fails++;
            $display("FAIL vsync_line1: vs=%b, want 1", a_vs);
        end
    endtask

    // Line 1: colour varies per pixel, garbage driven between ticks
    task automatic test_back_to_back();
        int unsigned bad, seen;
        logic        tick_now;
        logic [9:0]  x_now;
        logic [11:0] exp_rgb;
        logic [11:0] got;
        bad = 0; seen = 0; got = '0; exp_rgb = '0;
        for (int unsigned c = 0; c < 1300 && seen < 300; c++) begin
            data_a   = a_tick ? {a_x[3:0], a_x[7:4], ~a_x[3:0]} : 12'hFFF;
            tick_now = a_tick;
            x_now    = a_x;
            step();
            if (tick_now) begin
                seen++;
                if ({a_r, a_g, a_b} !== {x_now[3:0], x_now[7:4], ~x_now[3:0]}) begin
                    if (bad == 0) begin
                        got     = {a_r, a_g, a_b};
                        exp_rgb = {x_now[3:0], x_now[7:4], ~x_now[3:0]};
                    end
                    bad++;
                end
            end
        end
        tests++;
        if (seen !== 300 || bad !== 0) begin
            fails++;
            $display("FAIL pixel_pattern: %0d ticks seen, %0d wrong (first got %h want %h), want 300 0",
                     seen, bad, got, exp_rgb);
        end
    endtask

    // Instance B: two full frames with a tick on every clock
    task automatic test_frame();
        int unsigned fs_cnt, vs_low, vs_bad, fs_bad, von_bad, tick_miss, wraps;
        logic        fs_now, von_now;
        logic [9:0]  x_now, y_now;
        logic        exp_vs;
        fs_cnt = 0; vs_low = 0; vs_bad = 0; fs_bad = 0; von_bad = 0; tick_miss = 0; wraps = 0;
        rst_b = 1'b1;
        step();
        step();
        tests++;
        if (b_tick !== 1'b0 || b_fs !== 1'b0 || b_hs !== 1'b1 || b_vs !== 1'b1) begin
            fails++;
            $display("FAIL div1_reset: tick=%b fs=%b hs=%b vs=%b, want 0 0 1 1", b_tick, b_fs, b_hs, b_vs);
        end
        rst_b = 1'b0;
        step();
        tests++;
        if (b_tick !== 1'b1 || b_fs !== 1'b1) begin
            fails++;
            $display("FAIL div1_first_tick: tick=%b fs=%b, want 1 1", b_tick, b_fs);
        end
        for (int unsigned c = 0; c < 288; c++) begin
            if (b_tick !== 1'b1) tick_miss++;
            fs_now  = b_fs;
            von_now = b_von;
            x_now   = b_x;
            y_now   = b_y;
            if (fs_now) fs_cnt++;
            if (fs_now !== (x_now == 10'd0 && y_now == 10'd0)) fs_bad++;
            if (von_now !== (x_now < 10'd8 && y_now < 10'd4)) von_bad++;
            step();
            exp_vs = (y_now == 10'd5 || y_now == 10'd6) ? 1'b0 : 1'b1;
            if (b_vs == 1'b0) vs_low++;
            if (b_vs !== exp_vs) vs_bad++;
            if (x_now == 10'd15 && y_now == 10'd8) begin
                wraps++;
                if (b_x !== 10'd0 || b_y !== 10'd0) fs_bad++;
            end
        end
        tests++;
        if (tick_miss !== 0) begin
            fails++;
            $display("FAIL div1_tick_every_clk: %0d clks without tick, want 0", tick_miss);
        end
        tests++;
        if (fs_cnt !== 2 || fs_bad !== 0 || wraps !== 2) begin
            fails++;
            $display("FAIL frame_start: %0d pulses, %0d bad, %0d wraps, want 2 0 2", fs_cnt, fs_bad, wraps);
        end
        tests++;
        if (vs_low !== 64 || vs_bad !== 0) begin
            fails++;
            $display("FAIL vsync_window: %0d low ticks, %0d misplaced, want 64 0", vs_low, vs_bad);
        end
        tests++;
        if (von_bad !== 0) begin
            fails++;
            $display("FAIL video_on_decode: %0d wrong, want 0", von_bad);
        end
    endtask

    // Instance B: reset in the visible area and inside both sync pulses
    task automatic test_reset_midframe();
        logic [9:0] tx [2];
        logic [9:0] ty [2];
        logic       found;
        tx[0] = 10'd5;  ty[0] = 10'd2;
        tx[1] = 10'd11; ty[1] = 10'd5;
        data_b = 12'h5A5;
        for (int unsigned t = 0; t < 2; t++) begin
            found = 1'b0;
            for (int unsigned c = 0; c < 300 && !found; c++) begin
                if (b_x == tx[t] && b_y == ty[t]) found = 1'b1;
                else step();
            end
            tests++;
            if (!found) begin
                fails++;
                $display("FAIL midframe_reach_%0d: at x=%0d y=%0d, want x=%0d y=%0d", t, b_x, b_y, tx[t], ty[t]);
            end else begin
                tests++;
                if (t == 0 && {b_r, b_g, b_b} !== 12'h5A5) begin
                    fails++;
                    $display("FAIL midframe_pre_rgb: rgb=%h, want 5a5", {b_r, b_g, b_b});
                end
                if (t == 1 && (b_hs !== 1'b0 || b_vs !== 1'b0)) begin
                    fails++;
                    $display("FAIL midframe_pre_sync: hs=%b vs=%b, want 0 0", b_hs, b_vs);
                end
                rst_b = 1'b1;
                step();
                tests++;
                if ({b_tick, b_fs, b_x, b_y, b_hs, b_vs, b_r, b_g, b_b} !==
                    {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 12'h000}) begin
                    fails++;
                    $display("FAIL midframe_reset_%0d: tick=%b fs=%b x=%0d y=%0d hs=%b vs=%b rgb=%h, want 0 0 0 0 1 1 000",
                             t, b_tick, b_fs, b_x, b_y, b_hs, b_vs, {b_r, b_g, b_b});
                end
                rst_b = 1'b0;
                step();
                tests++;
                if (b_tick !== 1'b1 || b_x !== 10'd0 || b_y !== 10'd0) begin
                    fails++;
                    $display("FAIL midframe_restart_%0d: tick=%b x=%0d y=%0d, want 1 0 0", t, b_tick, b_x, b_y);
                end
            end
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    // Instance A: first two colour bars on line 0, data_in ignored
    task automatic test_pattern();
        int unsigned bad, seen;
        logic        tick_now;
        logic [9:0]  x_now;
        logic [11:0] got;
        bad = 0; seen = 0; got = '0;
        rst_a  = 1'b1;
        tm_a   = 1'b1;
        data_a = 12'h123;
        step();
        rst_a = 1'b0;
        for (int unsigned c = 0; c < 1100 && seen < 256; c++) begin
            tick_now = a_tick;
            x_now    = a_x;
            step();
            if (tick_now) begin
                seen++;
                if ({a_r, a_g, a_b} !== ((x_now < 10'd128) ? 12'hFFF : 12'hFF0)) begin
                    if (bad == 0) got = {a_r, a_g, a_b};
                    bad++;
                end
            end
        end
        tests++;
        if (seen !== 256 || bad !== 0) begin
            fails++;
            $display("FAIL test_pattern_bars: %0d ticks, %0d wrong (first rgb=%h), want 256 0", seen, bad, got);
        end
        tm_a = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_back_to_back();
        test_frame();
        test_reset_midframe();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
